// File: rtl/mult_arbiter_if.sv
// Request/response bundle between the two requesters and mult_arbiter.
// Index i of every two-entry field belongs to port i (0 = CPU, 1 = coprocessor).
interface mult_arbiter_if;
  logic [1:0]       req_valid_in;
  logic [1:0]       req_ready_out;
  logic [1:0][1:0]  req_op_in;
  logic [1:0][31:0] req_a_in;
  logic [1:0][31:0] req_b_in;
  logic [1:0]       resp_valid_out;
  logic [31:0]      resp_data_out;
  logic             busy_out;

  modport master (
    output req_valid_in, req_op_in, req_a_in, req_b_in,
    input  req_ready_out, resp_valid_out, resp_data_out, busy_out
  );

  modport slave (
    input  req_valid_in, req_op_in, req_a_in, req_b_in,
    output req_ready_out, resp_valid_out, resp_data_out, busy_out
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: two requesters share one pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Define MULT_ARB_RR_EN for round-robin conflicts; otherwise port 0 has fixed priority.
module mult_arbiter #(
  parameter int LATENCY = 2
) (
  input logic           clk_in,
  input logic           rst_in,
  mult_arbiter_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic        tag;
    logic [31:0] data;
  } stage_t;

  logic [1:0]  pick;
  logic [1:0]  grant;
  logic        issue_valid;
  logic        issue_port;
  logic [1:0]  issue_op;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic [31:0] result;
  logic        busy;
  stage_t      pipe [LATENCY];

`ifdef MULT_ARB_RR_EN
  logic prio;

  always_comb begin
    pick = bus.req_valid_in;
    if (bus.req_valid_in == 2'b11) begin
      pick = prio ? 2'b10 : 2'b01;
    end
  end

  // prio names the port that wins the next conflict: whoever did not just get a grant
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      prio <= 1'b0;
    end else if (|grant) begin
      prio <= grant[0];
    end
  end
`else
  always_comb begin
    pick = 2'b00;
    if (bus.req_valid_in[0]) begin
      pick = 2'b01;
    end else if (bus.req_valid_in[1]) begin
      pick = 2'b10;
    end
  end
`endif

  // Grant is masked by reset so ready drops immediately, not just on the next edge
  assign grant             = rst_in ? pick : 2'b00;
  assign bus.req_ready_out = grant;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      issue_valid <= 1'b0;
      issue_port  <= 1'b0;
      issue_op    <= 2'b00;
      issue_a     <= '0;
      issue_b     <= '0;
    end else begin
      issue_valid <= |grant;
      if (|grant) begin
        issue_port <= grant[1];
        issue_op   <= bus.req_op_in[grant[1]];
        issue_a    <= bus.req_a_in[grant[1]];
        issue_b    <= bus.req_b_in[grant[1]];
      end
    end
  end

  // Operands are extended to 64 bits so a wrapping 64-bit multiply yields the exact product
  always_comb begin
    a_ext   = {{32{(issue_op != 2'b11) & issue_a[31]}}, issue_a};
    b_ext   = {{32{~issue_op[1] & issue_b[31]}}, issue_b};
    product = a_ext * b_ext;
    result  = (issue_op == 2'b00) ? product[31:0] : product[63:32];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int k = 0; k < LATENCY; k++) begin
        pipe[k] <= '0;
      end
    end else begin
      pipe[0] <= '{valid: issue_valid, tag: issue_port, data: issue_valid ? result : 32'h0};
      for (int k = 1; k < LATENCY; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end
  end

  always_comb begin
    busy = issue_valid;
    for (int k = 0; k < LATENCY; k++) begin
      busy = busy | pipe[k].valid;
    end
  end

  assign bus.busy_out       = busy;
  assign bus.resp_valid_out = pipe[LATENCY-1].valid ? (pipe[LATENCY-1].tag ? 2'b10 : 2'b01) : 2'b00;
  assign bus.resp_data_out  = pipe[LATENCY-1].valid ? pipe[LATENCY-1].data : 32'h0;

endmodule
